// File: rtl/vram_fill_dp.sv
// vram_fill_dp: dual-port video RAM with a single-cycle host port, a streaming
// display read port and a fill engine that writes one value to every location.
module vram_fill_dp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 8192,
    parameter int DISP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWrData,
    input  logic              hostSelect,
    input  logic              hostRd,
    output logic [DATA_W-1:0] hostRdData,
    output logic              hostRdValid,
    output logic              hostBusy,
    input  logic              fillStart,
    input  logic [DATA_W-1:0] fillValue,
    output logic              fillBusy,
    output logic              fillDone,
    input  logic [ADDR_W-1:0] displayAddr,
    output logic [DATA_W-1:0] displayRdData
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state, stateNext;
    logic [ADDR_W-1:0] fillAddr;
    logic [DATA_W-1:0] fillVal, disp1, disp2;
    logic              hostOk, dispOk, hostAcc;

    assign fillBusy      = state == FILL;
    assign fillDone      = state == DONE;
    assign hostBusy      = fillBusy;
    assign hostOk        = {1'b0, hostAddr} < DEPTH_V;
    assign dispOk        = {1'b0, displayAddr} < DEPTH_V;
    assign hostAcc       = hostSelect && !hostBusy;
    assign displayRdData = DISP_LAT == 2 ? disp2 : disp1;

    always_comb begin
        stateNext = state == IDLE ? (fillStart ? FILL : IDLE) :
                    state == FILL ? (fillAddr == LAST ? DONE : FILL) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fillAddr <= '0;
            fillVal  <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && fillStart) begin
                fillAddr <= '0;
                fillVal  <= fillValue;
            end else if (fillBusy) begin
                fillAddr <= fillAddr + 1'b1;
            end
        end
    end

    // One write port shared by fill and host; fill owns it whenever hostBusy is high
    always_ff @(posedge clk) begin
        if (!rst && fillBusy)
            mem[fillAddr] <= fillVal;
        else if (!rst && hostAcc && !hostRd && hostOk)
            mem[hostAddr] <= hostWrData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hostRdData  <= '0;
            hostRdValid <= 1'b0;
            disp1       <= '0;
            disp2       <= '0;
        end else begin
            hostRdValid <= hostAcc && hostRd;
            if (hostAcc && hostRd)
                hostRdData <= hostOk ? mem[hostAddr] : '0;
            disp1 <= dispOk ? mem[displayAddr] : '0;
            disp2 <= disp1;
        end
    end
endmodule

// File: tb/tb_vram_fill_dp.sv
// tb_vram_fill_dp: drives two configurations (8192/lat1 and 4800/lat2) with one
// shared randomized stream and compares both against a behavioural memory model.
module tb_vram_fill_dp;
    logic        clk = 1'b0;
    logic        rst, hostSelect, hostRd, fillStart;
    logic [12:0] hostAddr, displayAddr;
    logic [7:0]  hostWrData, fillValue;
    logic [7:0]  oRd [2], oDisp [2];
    logic        oRdV [2], oHB [2], oFB [2], oFD [2];

    logic [7:0]  mMem [2][8192];
    bit          mKn [2][8192];
    bit          mFill [2], mDone [2], mRdV [2], mRdK [2], mS1k [2], mS2k [2];
    logic [7:0]  mRd [2], mS1 [2], mS2 [2], mFv [2];
    int          mPos [2];
    int          errors = 0, checks = 0;
    bit          holdDisp = 0;

    always #5 clk = ~clk;

    vram_fill_dp u0 (
        .clk(clk), .rst(rst), .hostAddr(hostAddr), .hostWrData(hostWrData),
        .hostSelect(hostSelect), .hostRd(hostRd), .hostRdData(oRd[0]),
        .hostRdValid(oRdV[0]), .hostBusy(oHB[0]), .fillStart(fillStart),
        .fillValue(fillValue), .fillBusy(oFB[0]), .fillDone(oFD[0]),
        .displayAddr(displayAddr), .displayRdData(oDisp[0])
    );

    vram_fill_dp #(.DEPTH(4800), .DISP_LAT(2)) u1 (
        .clk(clk), .rst(rst), .hostAddr(hostAddr), .hostWrData(hostWrData),
        .hostSelect(hostSelect), .hostRd(hostRd), .hostRdData(oRd[1]),
        .hostRdValid(oRdV[1]), .hostBusy(oHB[1]), .fillStart(fillStart),
        .fillValue(fillValue), .fillBusy(oFB[1]), .fillDone(oFD[1]),
        .displayAddr(displayAddr), .displayRdData(oDisp[1])
    );

    function automatic int depthOf(int k);
        return k == 1 ? 4800 : 8192;
    endfunction

    task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] pickAddr();
        case ($urandom_range(0, 4))
            0: return 13'($urandom_range(0, 15));
            1: return 13'($urandom_range(4790, 4810));
            2: return 13'd8191;
            3: return 13'($urandom_range(8180, 8191));
            default: return 13'($urandom);
        endcase
    endfunction

    // Model of one clock edge: reads see pre-edge memory, fill lasts exactly depth cycles
    task automatic modelStep();
        logic [7:0] dv;
        bit dk, acc;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mRd[k] = 0; mRdV[k] = 0; mRdK[k] = 1;
                mS1[k] = 0; mS2[k] = 0; mS1k[k] = 1; mS2k[k] = 1;
                mFill[k] = 0; mDone[k] = 0;
            end else begin
                dv = 0;
                dk = 1;
                if (int'(displayAddr) < depthOf(k)) begin
                    dv = mMem[k][displayAddr];
                    dk = mKn[k][displayAddr];
                end
                acc = hostSelect && !mFill[k];
                mRdV[k] = acc && hostRd;
                if (acc && hostRd) begin
                    mRd[k] = 0;
                    mRdK[k] = 1;
                    if (int'(hostAddr) < depthOf(k)) begin
                        mRd[k] = mMem[k][hostAddr];
                        mRdK[k] = mKn[k][hostAddr];
                    end
                end
                if (acc && !hostRd && int'(hostAddr) < depthOf(k)) begin
                    mMem[k][hostAddr] = hostWrData;
                    mKn[k][hostAddr] = 1;
                end
                if (mFill[k]) begin
                    mMem[k][mPos[k]] = mFv[k];
                    mKn[k][mPos[k]] = 1;
                    mPos[k]++;
                    if (mPos[k] == depthOf(k)) begin
                        mFill[k] = 0;
                        mDone[k] = 1;
                    end
                end else if (mDone[k]) begin
                    mDone[k] = 0;
                end else if (fillStart) begin
                    mFill[k] = 1;
                    mPos[k] = 0;
                    mFv[k] = fillValue;
                end
                mS2[k] = mS1[k]; mS2k[k] = mS1k[k];
                mS1[k] = dv;     mS1k[k] = dk;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        for (int k = 0; k < 2; k++) begin
            checkVal($sformatf("d%0d.hostBusy", k), 32'(oHB[k]), 32'(mFill[k]));
            checkVal($sformatf("d%0d.fillBusy", k), 32'(oFB[k]), 32'(mFill[k]));
            checkVal($sformatf("d%0d.fillDone", k), 32'(oFD[k]), 32'(mDone[k]));
            checkVal($sformatf("d%0d.hostRdValid", k), 32'(oRdV[k]), 32'(mRdV[k]));
            if (mRdK[k])
                checkVal($sformatf("d%0d.hostRdData", k), 32'(oRd[k]), 32'(mRd[k]));
            if (k == 1 ? mS2k[k] : mS1k[k])
                checkVal($sformatf("d%0d.displayRdData", k), 32'(oDisp[k]),
                         32'(k == 1 ? mS2[k] : mS1[k]));
        end
        if (!holdDisp)
            displayAddr = pickAddr();
    endtask

    task automatic hostOp(bit rd, logic [12:0] a, logic [7:0] d);
        hostSelect = 1; hostRd = rd; hostAddr = a; hostWrData = d;
        tick();
        hostSelect = 0;
    endtask

    task automatic startFill(logic [7:0] v);
        fillValue = v; fillStart = 1;
        tick();
        fillStart = 0;
    endtask

    // Random host traffic and stray fillStart pulses while any fill is running
    task automatic waitIdle(int limit);
        int n = 0;
        while ((mFill[0] || mDone[0] || mFill[1] || mDone[1]) && n < limit) begin
            hostSelect = 1'($urandom_range(0, 1));
            hostRd = 1'($urandom_range(0, 1));
            hostAddr = pickAddr();
            hostWrData = 8'($urandom);
            fillStart = (mFill[0] || mDone[0]) && $urandom_range(0, 3) == 0;
            tick();
            n++;
        end
        hostSelect = 0;
        fillStart = 0;
        checkVal("fillIdle", 32'(oFB[0] | oFB[1]), 0);
    endtask

    initial begin
        rst = 1; hostSelect = 0; hostRd = 0; fillStart = 0;
        hostAddr = 0; displayAddr = 0; hostWrData = 0; fillValue = 0;
        for (int k = 0; k < 2; k++) begin
            mFill[k] = 0; mDone[k] = 0; mRdV[k] = 0; mRdK[k] = 0; mS1k[k] = 0; mS2k[k] = 0;
            mRd[k] = 0; mS1[k] = 0; mS2[k] = 0; mFv[k] = 0; mPos[k] = 0;
            for (int a = 0; a < 8192; a++) mKn[k][a] = 0;
        end
        repeat (3) tick();
        rst = 0;
        startFill(8'h11);
        waitIdle(13100);
        tick();
        hostOp(0, 13'h10, 8'h5A);
        hostOp(1, 13'h10, 8'h00);
        repeat (2) tick();
        hostOp(0, 13'h100, 8'h11);
        holdDisp = 1;
        displayAddr = 13'h100;
        hostOp(0, 13'h100, 8'hC3);
        repeat (3) tick();
        hostOp(0, 13'd4800, 8'hEE);
        hostOp(1, 13'd4800, 8'h00);
        displayAddr = 13'd8191;
        hostOp(1, 13'd8191, 8'h00);
        repeat (3) tick();
        holdDisp = 0;
        repeat (3000) begin
            hostSelect = 1'($urandom_range(0, 1));
            hostRd = 1'($urandom_range(0, 1));
            hostAddr = pickAddr();
            hostWrData = 8'($urandom);
            tick();
        end
        hostSelect = 0;
        startFill(8'h77);
        repeat (100) tick();
        rst = 1;
        tick();
        rst = 0;
        for (int a = 97; a <= 102; a++) hostOp(1, 13'(a), 8'h00);
        tick();
        startFill(8'hA5);
        waitIdle(13100);
        repeat (30) hostOp(1, pickAddr(), 8'h00);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
